// File: rtl/sonic_cmd_mwr_receiver.sv
// sonic_cmd_mwr_receiver
//   Receive side of the command mailbox. It accepts host memory-write TLPs from
//   the PCIe hard-IP RX descriptor/data interface. A write that targets the
//   mailbox offset with the expected length and full byte enables is latched as
//   a 128-bit command (cmd_word = payload[127:64], cmd_arg = payload[63:0]). The
//   command is then held with a pending/ack handshake. Every other TLP is
//   accepted and its payload drained with no command.
//
// Ports
//   clk_in, reset (async, active-high), init (sync clear, same effect as reset)
//   rx_req/rx_sel/rx_desc  descriptor from the core; rx_ack is the accept pulse
//   rx_dfr/rx_dv/rx_data   data phase from the core; rx_ws is the wait state (always 0)
//   cmd_valid/cmd_pending/cmd_word/cmd_arg/cmd_ack  command processor handshake
//
// Optional feature (macro SONIC_CMD_RX_STATS_EN)
//   Adds the cnt_accepted[31:0] and cnt_dropped[31:0] TLP counters.
module sonic_cmd_mwr_receiver #(
  parameter logic [11:0] CMD_OFFSET  = 12'h000,
  parameter int          DATA_DWORDS = 4
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         init,
  input  logic         rx_req,
  input  logic         rx_sel,
  input  logic [127:0] rx_desc,
  output logic         rx_ack,
  input  logic         rx_dfr,
  input  logic         rx_dv,
  input  logic [127:0] rx_data,
  output logic         rx_ws,
  output logic         cmd_valid,
  output logic         cmd_pending,
  output logic [63:0]  cmd_word,
  output logic [63:0]  cmd_arg,
`ifdef SONIC_CMD_RX_STATS_EN
  output logic [31:0]  cnt_accepted,
  output logic [31:0]  cnt_dropped,
`endif
  input  logic         cmd_ack
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_DATA, S_DONE} state_t;

  state_t       state;
  logic         has_data;   // fmt[1]
  logic [4:0]   tlp_type;
  logic [9:0]   tlp_len;
  logic [3:0]   tlp_fbe;
  logic [3:0]   tlp_lbe;
  logic [11:0]  tlp_addr_lo; // address[11:0], already selected for 3DW/4DW
  logic [8:0]   beat_cnt;
  logic [127:0] staging;

  logic [10:0]  len_round;
  logic [8:0]   exp_beats;
  logic [8:0]   beat_next;
  logic         tlp_match;
  logic         unused_bits;

  // Number of data beats in the TLP; a length of 0 encodes 1024 DW.
  always_comb begin
    len_round = {1'b0, tlp_len} + 11'd3;
    if (tlp_len == 10'd0) begin
      exp_beats = 9'd256;
    end else begin
      exp_beats = len_round[10:2];
    end
  end

  assign beat_next = beat_cnt + 9'd1;

  // Mailbox match, decoded from the latched descriptor.
  always_comb begin
    tlp_match = (tlp_type == 5'b00000) &&
                (tlp_len == DATA_DWORDS[9:0]) &&
                (tlp_fbe == 4'hF) && (tlp_lbe == 4'hF) &&
                (tlp_addr_lo == CMD_OFFSET);
  end

  // Descriptor fields and data-phase signals this block does not need.
  assign unused_bits = ^{rx_dfr, rx_desc[127], rx_desc[119:106], rx_desc[95:72],
                         rx_desc[63:44], rx_desc[31:12], len_round[1:0]};

  // Receive FSM with its registered handshake and command outputs.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      has_data    <= 1'b0;
      tlp_type    <= 5'd0;
      tlp_len     <= 10'd0;
      tlp_fbe     <= 4'd0;
      tlp_lbe     <= 4'd0;
      tlp_addr_lo <= 12'd0;
      beat_cnt    <= 9'd0;
      staging     <= 128'd0;
      rx_ack      <= 1'b0;
      rx_ws       <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_pending <= 1'b0;
      cmd_word    <= 64'd0;
      cmd_arg     <= 64'd0;
    end else if (init) begin
      state       <= S_IDLE;
      has_data    <= 1'b0;
      tlp_type    <= 5'd0;
      tlp_len     <= 10'd0;
      tlp_fbe     <= 4'd0;
      tlp_lbe     <= 4'd0;
      tlp_addr_lo <= 12'd0;
      beat_cnt    <= 9'd0;
      staging     <= 128'd0;
      rx_ack      <= 1'b0;
      rx_ws       <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_pending <= 1'b0;
      cmd_word    <= 64'd0;
      cmd_arg     <= 64'd0;
    end else begin
      rx_ack    <= 1'b0;
      rx_ws     <= 1'b0;
      cmd_valid <= 1'b0;
      if (cmd_pending && cmd_ack) begin
        cmd_pending <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          // A pending command stalls acceptance of the next descriptor.
          if (rx_req && rx_sel && !cmd_pending) begin
            has_data <= rx_desc[126];
            tlp_type <= rx_desc[124:120];
            tlp_len  <= rx_desc[105:96];
            tlp_lbe  <= rx_desc[71:68];
            tlp_fbe  <= rx_desc[67:64];
            // 4DW carries the low address DW in [31:0]; 3DW carries it in [63:32].
            tlp_addr_lo <= rx_desc[125] ? rx_desc[11:0] : rx_desc[43:32];
            rx_ack   <= 1'b1;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          beat_cnt <= 9'd0;
          if (has_data) begin
            state <= S_DATA;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          // Only the beat count ends the phase; rx_dfr is not used.
          if (rx_dv) begin
            beat_cnt <= beat_next;
            if (beat_cnt == 9'd0) begin
              staging <= rx_data;
            end
            if (beat_next == exp_beats) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Placed after the ack clear so a same-cycle cmd_ack loses to the set.
          if (tlp_match) begin
            cmd_word    <= staging[127:64];
            cmd_arg     <= staging[63:0];
            cmd_pending <= 1'b1;
            cmd_valid   <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SONIC_CMD_RX_STATS_EN
  // TLP statistics: accepted mailbox writes and everything else.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_accepted <= 32'd0;
      cnt_dropped  <= 32'd0;
    end else if (init) begin
      cnt_accepted <= 32'd0;
      cnt_dropped  <= 32'd0;
    end else begin
      if ((state == S_DONE) && tlp_match) begin
        cnt_accepted <= cnt_accepted + 32'd1;
      end
      if (((state == S_DONE) && !tlp_match) || ((state == S_ACK) && !has_data)) begin
        cnt_dropped <= cnt_dropped + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sonic_cmd_mwr_receiver.sv
// Self-checking bench for sonic_cmd_mwr_receiver. Expected commands are queued
// when a matching TLP is driven. A monitor pops them and compares them when
// cmd_valid pulses.
module tb_sonic_cmd_mwr_receiver;

  logic         clk_in = 1'b0;
  logic         reset;
  logic         init;
  logic         rx_req;
  logic         rx_sel;
  logic [127:0] rx_desc;
  logic         rx_ack;
  logic         rx_dfr;
  logic         rx_dv;
  logic [127:0] rx_data;
  logic         rx_ws;
  logic         cmd_valid;
  logic         cmd_pending;
  logic [63:0]  cmd_word;
  logic [63:0]  cmd_arg;
  logic         cmd_ack;
`ifdef SONIC_CMD_RX_STATS_EN
  logic [31:0]  cnt_accepted;
  logic [31:0]  cnt_dropped;
`endif

  int tests = 0;
  int fails = 0;
  int exp_acc = 0;
  int exp_drop = 0;
  logic [127:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  sonic_cmd_mwr_receiver dut (
    .clk_in(clk_in), .reset(reset), .init(init),
    .rx_req(rx_req), .rx_sel(rx_sel), .rx_desc(rx_desc), .rx_ack(rx_ack),
    .rx_dfr(rx_dfr), .rx_dv(rx_dv), .rx_data(rx_data), .rx_ws(rx_ws),
    .cmd_valid(cmd_valid), .cmd_pending(cmd_pending),
    .cmd_word(cmd_word), .cmd_arg(cmd_arg),
`ifdef SONIC_CMD_RX_STATS_EN
    .cnt_accepted(cnt_accepted), .cnt_dropped(cnt_dropped),
`endif
    .cmd_ack(cmd_ack)
  );

  // Scoreboard monitor: every cmd_valid pulse must match the oldest queued command.
  always @(negedge clk_in) begin
    logic [127:0] e;
    if (cmd_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_cmd: got word=%h arg=%h, required no cmd_valid", cmd_word, cmd_arg);
      end else begin
        e = exp_q.pop_front();
        if ({cmd_word, cmd_arg} !== e || cmd_pending !== 1'b1) begin
          fails++;
          $display("FAIL cmd_capture: got word=%h arg=%h pend=%b, required word=%h arg=%h pend=1",
                   cmd_word, cmd_arg, cmd_pending, e[127:64], e[63:0]);
        end
      end
    end
  end

  function automatic logic [127:0] mk_desc(input logic [1:0] fmt, input logic [4:0] typ,
                                           input logic [9:0] len, input logic [3:0] fbe,
                                           input logic [3:0] lbe, input logic [63:0] addr);
    logic [127:0] d;
    d = 128'd0;
    d[126:125] = fmt;
    d[124:120] = typ;
    d[105:96]  = len;
    d[71:68]   = lbe;
    d[67:64]   = fbe;
    if (fmt == 2'b11) begin
      d[63:0] = addr;
    end else begin
      d[63:32] = addr[31:0];
      d[31:0]  = 32'hDEAD_B0A0;  // must be ignored for 3DW
    end
    return d;
  endfunction

  task automatic start_req(input logic [127:0] d);
    @(negedge clk_in);
    rx_desc = d;
    rx_req  = 1'b1;
    rx_sel  = 1'b1;
  endtask

  task automatic wait_ack(output int n);
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk_in);
      #1;
      n++;
      if (rx_ack === 1'b1) got = 1'b1;
    end
    if (!got) n = 99;
  endtask

  task automatic check_stats(input string name);
`ifdef SONIC_CMD_RX_STATS_EN
    tests++;
    if (cnt_accepted !== exp_acc[31:0] || cnt_dropped !== exp_drop[31:0]) begin
      fails++;
      $display("FAIL %s_stats: got acc=%0d drop=%0d, required acc=%0d drop=%0d",
               name, cnt_accepted, cnt_dropped, exp_acc, exp_drop);
    end
`else
    if (name.len() == 0) $display("[TB] unnamed stats check");
`endif
  endtask

  // Called with the DUT in its ACK cycle: releases req, drains beats, settles.
  task automatic finish_tlp(input string name, input int nbeats, input logic [127:0] data,
                            input bit match, input bit ack_in_done);
    bit ws_seen;
    ws_seen = 1'b0;
    @(negedge clk_in);
    rx_req = 1'b0;
    rx_sel = 1'b0;
    @(posedge clk_in);
    #1;
    tests++;
    if (rx_ack !== 1'b0) begin
      fails++;
      $display("FAIL %s_ack_pulse: got rx_ack=%b, required 0", name, rx_ack);
    end
    if (match) begin
      exp_q.push_back(data);
      exp_acc++;
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk_in);
      if (rx_ws !== 1'b0) ws_seen = 1'b1;
      rx_dv   = 1'b1;
      rx_dfr  = (i == 0);  // drops early; must not end the phase
      rx_data = (i == 0) ? data : ~data;
    end
    @(negedge clk_in);
    rx_dv   = 1'b0;
    rx_dfr  = 1'b0;
    cmd_ack = ack_in_done;
    @(negedge clk_in);
    cmd_ack = 1'b0;
    repeat (2) @(negedge clk_in);
    tests++;
    if (ws_seen) begin
      fails++;
      $display("FAIL %s_rx_ws: got rx_ws=1 during data, required 0", name);
    end
    check_stats(name);
  endtask

  task automatic send_tlp(input string name, input logic [1:0] fmt, input logic [4:0] typ,
                          input logic [9:0] len, input logic [3:0] fbe, input logic [3:0] lbe,
                          input logic [63:0] addr, input int nbeats, input logic [127:0] data,
                          input bit match, input bit ack_in_done);
    int n;
    start_req(mk_desc(fmt, typ, len, fbe, lbe, addr));
    wait_ack(n);
    tests++;
    if (n != 1) begin
      fails++;
      $display("FAIL %s_ack_latency: got %0d cycles, required 1", name, n);
    end
    finish_tlp(name, nbeats, data, match, ack_in_done);
  endtask

  task automatic ack_cmd(input string name);
    @(negedge clk_in);
    cmd_ack = 1'b1;
    @(negedge clk_in);
    cmd_ack = 1'b0;
    tests++;
    if (cmd_pending !== 1'b0) begin
      fails++;
      $display("FAIL %s_ack_clear: got cmd_pending=%b, required 0", name, cmd_pending);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    tests++;
    if ({rx_ack, rx_ws, cmd_valid, cmd_pending} !== 4'b0000 || cmd_word !== 64'd0 || cmd_arg !== 64'd0) begin
      fails++;
      $display("FAIL %s: got ack=%b ws=%b valid=%b pend=%b word=%h arg=%h, required all 0",
               name, rx_ack, rx_ws, cmd_valid, cmd_pending, cmd_word, cmd_arg);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0; rx_req = 1'b0; rx_sel = 1'b0; rx_desc = 128'd0;
    rx_dfr = 1'b0; rx_dv = 1'b0; rx_data = 128'd0; cmd_ack = 1'b0;
    repeat (3) @(negedge clk_in);
    check_outputs_zero("reset_state");
    reset = 1'b0;
    @(negedge clk_in);
    check_outputs_zero("after_reset");
    check_stats("reset");
  endtask

  task automatic test_match_3dw();
    send_tlp("match3dw", 2'b10, 5'd0, 10'd4, 4'hF, 4'hF, 64'h0, 1,
             {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, 1'b1, 1'b0);
    tests++;
    if (cmd_pending !== 1'b1 || cmd_word !== 64'h1111_1111_1111_1111 || cmd_arg !== 64'h2222_2222_2222_2222) begin
      fails++;
      $display("FAIL match3dw_hold: got pend=%b word=%h arg=%h, required pend=1 word=1111.. arg=2222..",
               cmd_pending, cmd_word, cmd_arg);
    end
    ack_cmd("match3dw");
  endtask

  task automatic test_match_4dw();
    send_tlp("match4dw", 2'b11, 5'd0, 10'd4, 4'hF, 4'hF, 64'h1_0000_0000, 1,
             {64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444}, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    bit acked;
    acked = 1'b0;
    start_req(mk_desc(2'b10, 5'd0, 10'd4, 4'hF, 4'hF, 64'h0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in);
      #1;
      if (rx_ack === 1'b1) acked = 1'b1;
    end
    tests++;
    if (acked || cmd_word !== 64'h3333_3333_3333_3333) begin
      fails++;
      $display("FAIL b2b_stall: got acked=%b word=%h, required acked=0 word=3333..", acked, cmd_word);
    end
    @(negedge clk_in);
    cmd_ack = 1'b1;
    @(negedge clk_in);
    cmd_ack = 1'b0;
    wait_ack(n);
    tests++;
    if (n > 2) begin
      fails++;
      $display("FAIL b2b_release: got %0d cycles, required at most 2", n);
    end
    finish_tlp("b2b", 1, {64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666}, 1'b1, 1'b0);
    ack_cmd("b2b");
  endtask

  task automatic test_mismatch();
    logic [63:0] w0;
    w0 = cmd_word;
    send_tlp("len8",  2'b10, 5'd0, 10'd8, 4'hF, 4'hF, 64'h0,   2, {2{64'hAAAA_0000_BBBB_0001}}, 1'b0, 1'b0);
    send_tlp("off010", 2'b10, 5'd0, 10'd4, 4'hF, 4'hF, 64'h10, 1, {2{64'hAAAA_0000_BBBB_0002}}, 1'b0, 1'b0);
    send_tlp("fbe3",  2'b11, 5'd0, 10'd4, 4'h3, 4'hF, 64'h0,   1, {2{64'hAAAA_0000_BBBB_0003}}, 1'b0, 1'b0);
    send_tlp("type1", 2'b10, 5'd1, 10'd4, 4'hF, 4'hF, 64'h0,   1, {2{64'hAAAA_0000_BBBB_0004}}, 1'b0, 1'b0);
    send_tlp("read",  2'b00, 5'd0, 10'd4, 4'hF, 4'hF, 64'h0,   0, 128'd0,                       1'b0, 1'b0);
    send_tlp("len0",  2'b10, 5'd0, 10'd0, 4'hF, 4'hF, 64'h0, 256, {2{64'hAAAA_0000_BBBB_0005}}, 1'b0, 1'b0);
    tests++;
    if (cmd_word !== w0 || cmd_pending !== 1'b0) begin
      fails++;
      $display("FAIL mismatch_hold: got word=%h pend=%b, required word=%h pend=0", cmd_word, cmd_pending, w0);
    end
  endtask

  task automatic test_ack_collision();
    ack_cmd("idle_ack");
    send_tlp("collide", 2'b10, 5'd0, 10'd4, 4'hF, 4'hF, 64'h0, 1,
             {64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888}, 1'b1, 1'b1);
    tests++;
    if (cmd_pending !== 1'b1) begin
      fails++;
      $display("FAIL collide_set_wins: got cmd_pending=%b, required 1", cmd_pending);
    end
  endtask

  task automatic test_init();
    @(negedge clk_in);
    init = 1'b1;
    @(negedge clk_in);
    init = 1'b0;
    exp_acc = 0;
    exp_drop = 0;
    check_outputs_zero("init_clear");
    check_stats("init");
  endtask

  task automatic test_reset_mid_data();
    int n;
    start_req(mk_desc(2'b10, 5'd0, 10'd8, 4'hF, 4'hF, 64'h0));
    wait_ack(n);
    @(negedge clk_in);
    rx_req = 1'b0;
    rx_sel = 1'b0;
    @(negedge clk_in);
    rx_dv = 1'b1;
    rx_data = {2{64'hDEAD_DEAD_DEAD_DEAD}};
    @(negedge clk_in);
    rx_dv = 1'b0;
    reset = 1'b1;
    #1;
    check_outputs_zero("reset_mid_data");
    @(negedge clk_in);
    reset = 1'b0;
    exp_acc = 0;
    exp_drop = 0;
    send_tlp("post_reset", 2'b10, 5'd0, 10'd4, 4'hF, 4'hF, 64'h0, 1,
             {64'h9999_9999_9999_9999, 64'hCCCC_CCCC_CCCC_CCCC}, 1'b1, 1'b0);
    ack_cmd("post_reset");
  endtask

  initial begin
    test_reset();
    test_match_3dw();
    test_match_4dw();
    test_back_to_back();
    test_mismatch();
    test_ack_collision();
    test_init();
    test_reset_mid_data();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_cmds: got %0d commands never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
